led_seq_ctrl: RTL and testbench
===============================

# led_seq_ctrl

Multi-channel LED sequencer that drives `NLED` board LEDs from a single 50 MHz clock, with a shared tick prescaler. Each channel is configured through a one-command-per-cycle valid/ready port as off, steady on, continuous blink, or a counted burst of blinks. It sits between the board-level control logic (keys/switches or a higher controller) and the `LEDG` pins, and replaces per-LED free-running blink counters.

## Interface
- `CLK_DIV`, 50: clock cycles per tick; legal values are ≥ 2.
- `NLED`, 4: number of LED channels; legal range is 1..4.
- `CLOCK_50`  in  1  system clock; all logic is on the rising edge.
- `KEY`  in  1  reset: synchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `cmd_led`  in  2  target channel index; must be < `NLED`.
- `cmd_mode`  in  2  command mode:
  - 00 = OFF
  - 01 = ON
  - 10 = BLINK
  - 11 = BURST
- `cmd_half`  in  4  half-period in ticks; 0 is treated as 1.
- `cmd_count`  in  4  number of burst pulses (BURST only).
- `LEDG`  out  `NLED`  LED outputs, registered.
- `busy`  out  `NLED`  channel is in BURST.
- `done`  out  `NLED`  one-cycle pulse when a channel's burst completes.

## Operation
- **Prescaler.** `pre` counts 0..`CLK_DIV`-1 and wraps. `tick` is high for the single cycle in which `pre`=`CLK_DIV`-1. The prescaler is free-running and is shared by all channels.
- **Per-channel state:** `st` ∈ {OFF, ON, BLINK, BURST}, `half` (4b), `phase` (4b), `rem` (4b), `led`.
- **Handshake.** A command is accepted when `cmd_valid` & `cmd_ready`.
  - `cmd_ready` is combinational: it is 0 during reset, and 0 when channel `cmd_led` is in BURST and `cmd_mode`≠OFF.
  - Otherwise `cmd_ready` is 1. OFF is always accepted, so OFF aborts a burst.
  - A command with `cmd_led` ≥ `NLED` is accepted and ignored.
- **Effect of an accepted command** (applied at the next clock edge):
  - OFF: st=OFF, led=0. An aborted burst does not pulse `done`.
  - ON: st=ON, led=1.
  - BLINK: st=BLINK, led=1, phase=0, half=max(`cmd_half`,1).
  - BURST with `cmd_count`≠0: st=BURST, led=1, phase=0, half=max(`cmd_half`,1), rem=`cmd_count`.
  - BURST with `cmd_count`=0: st=OFF, led=0, `done[i]` pulses in the following cycle.
- **BLINK / BURST on `tick`.**
  - If phase=half-1: phase=0 and led toggles.
  - Otherwise phase increments by 1.
- **Burst counting.** In BURST, each 1→0 toggle decrements `rem`.
  - When that decrement takes `rem` from 1 to 0, the same edge sets st=OFF and led=0 (already 0).
  - `done[i]`=1 for exactly the following cycle.
- **Outputs.** `busy[i]` = (st==BURST). `LEDG[i]` = led.

## Timing
- **Reset.** While `KEY`=1 at a clock edge:
  - pre=0; all channels OFF; phase, rem and half are cleared.
  - `LEDG`=0, `busy`=0, `done`=0.
  - Reset mid-burst aborts the burst without a `done` pulse.
  - The first `tick` occurs `CLK_DIV` cycles after the first edge with `KEY`=0.
- **Command latency.** A command accepted at edge N is visible on `LEDG` and `busy` after edge N.
- **First toggle after BLINK/BURST.** It occurs between (half-1)·`CLK_DIV`+1 and half·`CLK_DIV` cycles after acceptance, because the prescaler phase is not realigned.
- **Toggle spacing.** Subsequent toggles are exactly half·`CLK_DIV` cycles apart.
- **Burst duration.** A burst of count C produces C high pulses, each half·`CLK_DIV` cycles wide, and ends with `LEDG`=0. `done` is asserted one cycle after the final falling edge.
- **Command on a tick.** If a command hits channel i in the same cycle as `tick`, the command wins and the tick is ignored for channel i. Other channels process the tick normally.
- **Simultaneous completions.** Several channels finishing on the same tick pulse their `done` bits in the same cycle.
- **Widths.**
  - `pre` is $clog2(`CLK_DIV`) bits.
  - phase, rem and half are 4 bits each. Counters never wrap past their limits; phase is reset at half-1.

## Test plan
- **Reset and defaults** (`CLK_DIV`=4): hold `KEY`=1 for 3 cycles with random `cmd_valid` → `LEDG`=0, `busy`=0, `done`=0, `cmd_ready`=0; `cmd_ready`=1 once `KEY`=0.
- **Steady on and off:** ON to channel 2, then OFF to channel 2 → `LEDG`=4'b0100 one cycle after acceptance, then 4'b0000 one cycle after the OFF.
- **Continuous blink:** BLINK on channel 0 with half=2 → `LEDG[0]`=1 immediately; toggles every 8 cycles after the first toggle; first toggle within 5..8 cycles.
- **Burst:** BURST on channel 1 with half=1, count=3 →
  - exactly 3 high pulses of 4 cycles each;
  - `busy[1]` high throughout;
  - `done[1]`=1 for one cycle after the 3rd falling edge;
  - `LEDG[1]`=0 and `busy[1]`=0 afterwards.
- **Backpressure and abort:** during the burst, send BLINK to channel 1 → `cmd_ready`=0 and the burst is unaffected; then send OFF to channel 1 → accepted, `LEDG[1]`=0, `busy[1]`=0, no `done` pulse.
- **Edge cases:**
  - BURST with count=0 → `done` pulses for one cycle and the LED stays 0.
  - A command with `cmd_half`=0 behaves as half=1.
  - `KEY`=1 mid-burst → everything returns to 0 with no `done` pulse.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: multi-channel LED sequencer with a shared tick prescaler.
// Each channel can be off, steady on, blinking, or running a counted burst
// of blinks. Channels are configured through a single valid/ready port.
module led_seq_ctrl #(
  parameter int CLK_DIV = 50,
  parameter int NLED    = 4
) (
  input  logic            CLOCK_50,
  input  logic            KEY,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_led,
  input  logic [1:0]      cmd_mode,
  input  logic [3:0]      cmd_half,
  input  logic [3:0]      cmd_count,
  output logic [NLED-1:0] LEDG,
  output logic [NLED-1:0] busy,
  output logic [NLED-1:0] done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_ON    = 2'b01,
    ST_BLINK = 2'b10,
    ST_BURST = 2'b11
  } st_t;

  // Complete per-channel state; ch_q is the observable FSM state of each channel.
  typedef struct packed {
    st_t        st;
    logic [3:0] half;
    logic [3:0] phase;
    logic [3:0] rem;
    logic       led;
  } ch_t;

  ch_t             ch_q [NLED];
  ch_t             ch_d [NLED];
  logic [NLED-1:0] done_d;
  logic [NLED-1:0] done_q;
  logic [PW-1:0]   pre_q;
  logic            tick;
  logic            sel_burst;
  logic            accept;
  logic [3:0]      half_eff;

  assign tick     = (pre_q == PRE_MAX);
  assign half_eff = (cmd_half == 4'd0) ? 4'd1 : cmd_half;

  // Free-running prescaler shared by every channel.
  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready
  // are both high. cmd_ready is combinational; it drops during reset and when
  // the addressed channel is mid-burst and the command is not OFF, so OFF can
  // always abort a burst. Indices with no channel are accepted and dropped.
  always_comb begin
    sel_burst = 1'b0;
    for (int i = 0; i < NLED; i++) begin
      if (cmd_led == 2'(i) && ch_q[i].st == ST_BURST) sel_burst = 1'b1;
    end
    cmd_ready = !KEY && !(sel_burst && cmd_mode != 2'b00);
    accept    = cmd_valid && cmd_ready;
  end

  // Per-channel next state: an accepted command wins over a same-cycle tick.
  always_comb begin
    for (int i = 0; i < NLED; i++) begin
      ch_d[i]   = ch_q[i];
      done_d[i] = 1'b0;
      if (accept && cmd_led == 2'(i)) begin
        case (cmd_mode)
          2'b00: begin
            ch_d[i].st  = ST_OFF;
            ch_d[i].led = 1'b0;
          end
          2'b01: begin
            ch_d[i].st  = ST_ON;
            ch_d[i].led = 1'b1;
          end
          2'b10: begin
            ch_d[i].st    = ST_BLINK;
            ch_d[i].led   = 1'b1;
            ch_d[i].phase = 4'd0;
            ch_d[i].half  = half_eff;
          end
          default: begin
            if (cmd_count == 4'd0) begin
              ch_d[i].st  = ST_OFF;
              ch_d[i].led = 1'b0;
              done_d[i]   = 1'b1;
            end else begin
              ch_d[i].st    = ST_BURST;
              ch_d[i].led   = 1'b1;
              ch_d[i].phase = 4'd0;
              ch_d[i].half  = half_eff;
              ch_d[i].rem   = cmd_count;
            end
          end
        endcase
      end else if (tick && (ch_q[i].st == ST_BLINK || ch_q[i].st == ST_BURST)) begin
        if (ch_q[i].phase == ch_q[i].half - 4'd1) begin
          ch_d[i].phase = 4'd0;
          ch_d[i].led   = ~ch_q[i].led;
          // Only falling toggles consume a burst pulse.
          if (ch_q[i].st == ST_BURST && ch_q[i].led) begin
            ch_d[i].rem = ch_q[i].rem - 4'd1;
            if (ch_q[i].rem == 4'd1) begin
              ch_d[i].st = ST_OFF;
              done_d[i]  = 1'b1;
            end
          end
        end else begin
          ch_d[i].phase = ch_q[i].phase + 4'd1;
        end
      end
    end
  end

  // Channel state and done-pulse registers.
  always_ff @(posedge CLOCK_50) begin
    if (KEY) begin
      for (int i = 0; i < NLED; i++) ch_q[i] <= '0;
      done_q <= '0;
    end else begin
      for (int i = 0; i < NLED; i++) ch_q[i] <= ch_d[i];
      done_q <= done_d;
    end
  end

  // Outputs come straight from registered channel state.
  always_comb begin
    for (int i = 0; i < NLED; i++) begin
      LEDG[i] = ch_q[i].led;
      busy[i] = (ch_q[i].st == ST_BURST);
    end
    done = done_q;
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed bench with a tick-counting behavioural model.
module tb_led_seq_ctrl;

  localparam int DIV = 4;
  localparam int N   = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       key = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_led = '0;
  logic [1:0] cmd_mode = '0;
  logic [3:0] cmd_half = '0;
  logic [3:0] cmd_count = '0;
  logic [N-1:0] ledg, busy, done;

  always #10 clk = ~clk;

  led_seq_ctrl #(.CLK_DIV(DIV), .NLED(N)) dut (
    .CLOCK_50 (clk),
    .KEY      (key),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_led  (cmd_led),
    .cmd_mode (cmd_mode),
    .cmd_half (cmd_half),
    .cmd_count(cmd_count),
    .LEDG     (ledg),
    .busy     (busy),
    .done     (done)
  );

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  logic [7:0] exp_q[$];

  // ---------------- behavioural model ----------------
  // Each active channel counts ticks since its command; the LED level is the
  // parity of whole half-periods elapsed, and a burst of C pulses ends after
  // 2C-1 half-periods (the last falling edge).
  int m_cyc;
  int m_mode [N];
  int m_half [N];
  int m_cnt  [N];
  int m_t    [N];
  bit m_done [N];

  function automatic bit m_ready();
    return !key && !(m_mode[cmd_led] == 3 && cmd_mode != 2'b00);
  endfunction

  function automatic bit m_led(int i);
    if (m_mode[i] == 0) return 1'b0;
    if (m_mode[i] == 1) return 1'b1;
    return ((m_t[i] / m_half[i]) % 2) == 0;
  endfunction

  always @(posedge clk) begin
    bit acc, tck;
    acc = cmd_valid && m_ready();
    tck = (m_cyc % DIV) == DIV - 1;
    if (key) begin
      m_cyc = 0;
      for (int i = 0; i < N; i++) begin
        m_mode[i] = 0; m_half[i] = 1; m_cnt[i] = 0; m_t[i] = 0; m_done[i] = 1'b0;
      end
    end else begin
      m_cyc++;
      for (int i = 0; i < N; i++) begin
        m_done[i] = 1'b0;
        if (acc && int'(cmd_led) == i) begin
          m_mode[i] = int'(cmd_mode);
          m_t[i]    = 0;
          m_half[i] = (cmd_half == 0) ? 1 : int'(cmd_half);
          m_cnt[i]  = int'(cmd_count);
          if (cmd_mode == 2'b11 && cmd_count == 0) begin
            m_mode[i] = 0;
            m_done[i] = 1'b1;
          end
        end else if (tck && m_mode[i] >= 2) begin
          m_t[i]++;
          if (m_mode[i] == 3 && m_t[i] == m_half[i] * (2 * m_cnt[i] - 1)) begin
            m_mode[i] = 0;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      logic [N-1:0] e_led, e_busy, e_done;
      bit e_rdy;
      for (int i = 0; i < N; i++) begin
        e_led[i]  = m_led(i);
        e_busy[i] = (m_mode[i] == 3);
        e_done[i] = m_done[i];
      end
      e_rdy = m_ready();
      checks++;
      if (ledg !== e_led || busy !== e_busy || done !== e_done || cmd_ready !== e_rdy) begin
        errors++;
        $display("FAIL model_cmp t=%0t ledg=%b exp %b busy=%b exp %b done=%b exp %b ready=%b exp %b",
                 $time, ledg, e_led, busy, e_busy, done, e_done, cmd_ready, e_rdy);
      end
    end
  end

  // ---------------- driver / checker tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Every task starts and ends 2 time units after a rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Command transfers on the next rising edge.
  task automatic send(input int led, input int mode, input int half, input int cnt);
    cmd_valid = 1'b1;
    cmd_led   = 2'(led);
    cmd_mode  = 2'(mode);
    cmd_half  = 4'(half);
    cmd_count = 4'(cnt);
    step();
    cmd_valid = 1'b0;
  endtask

  // Position so the next rising edge is a prescaler tick.
  task automatic align_tick();
    for (int k = 0; k < DIV && (m_cyc % DIV) != DIV - 1; k++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int n, w, falls, done_cyc;
    bit prev;

    // Reset with random command traffic.
    @(posedge clk);
    #2;
    cmp_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_led   = 2'($urandom_range(0, 3));
      cmd_mode  = 2'($urandom_range(0, 3));
      cmd_half  = 4'($urandom_range(0, 15));
      cmd_count = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk("reset_ledg", int'(ledg), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_ready", int'(cmd_ready), 0);
      step();
    end
    cmd_valid = 1'b0;
    key = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(cmd_ready), 1);
    step();

    // Steady on / off on channel 2.
    send(2, 1, 0, 0);
    @(negedge clk);
    chk("on_ch2", int'(ledg), 4);
    step();
    send(2, 0, 0, 0);
    @(negedge clk);
    chk("off_ch2", int'(ledg), 0);
    step();

    // Continuous blink on channel 0, half = 2.
    send(0, 2, 2, 0);
    chk("blink_start", int'(ledg[0]), 1);
    n = 0;
    do begin step(); n++; end while (ledg[0] != 1'b0 && n < 20);
    chk_rng("blink_first_toggle", n, 5, 8);
    n = 0;
    do begin step(); n++; end while (ledg[0] != 1'b1 && n < 20);
    chk("blink_spacing1", n, 8);
    n = 0;
    do begin step(); n++; end while (ledg[0] != 1'b0 && n < 20);
    chk("blink_spacing2", n, 8);
    send(0, 0, 0, 0);

    // Burst of 3 on channel 1, half = 1, accepted on a tick edge.
    repeat (3) exp_q.push_back(8'd4);
    align_tick();
    send(1, 3, 1, 3);
    w = 1; falls = 0; done_cyc = 0; prev = 1'b1; n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      step();
      if (done[1]) done_cyc++;
      if (done_cyc > 0) n++;
      if (ledg[1]) begin
        w++;
        if (!busy[1]) chk("burst_busy_high", 0, 1);
      end else if (prev) begin
        falls++;
        if (exp_q.size() > 0) chk("burst_pulse_width", w, int'(exp_q.pop_front()));
        else chk("burst_extra_pulse", falls, 3);
        w = 0;
      end
      prev = ledg[1];
    end
    chk("burst_pulses", falls, 3);
    chk("burst_queue_left", exp_q.size(), 0);
    chk("burst_done_cycles", done_cyc, 1);
    chk("burst_end_led", int'(ledg[1]), 0);
    chk("burst_end_busy", int'(busy[1]), 0);

    // Backpressure during a burst, then OFF aborts it.
    send(1, 3, 2, 2);
    cmd_valid = 1'b1; cmd_led = 2'd1; cmd_mode = 2'b10; cmd_half = 4'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready_low", int'(cmd_ready), 0);
      chk("bp_busy", int'(busy[1]), 1);
      step();
    end
    cmd_valid = 1'b0;
    send(1, 0, 0, 0);
    @(negedge clk);
    chk("abort_led", int'(ledg[1]), 0);
    chk("abort_busy", int'(busy[1]), 0);
    done_cyc = 0;
    for (int k = 0; k < 12; k++) begin step(); if (done != 0) done_cyc++; end
    chk("abort_no_done", done_cyc, 0);

    // Burst with count 0 on channel 3.
    send(3, 3, 5, 0);
    @(negedge clk);
    chk("burst0_done", int'(done), 8);
    chk("burst0_led", int'(ledg[3]), 0);
    step();
    @(negedge clk);
    chk("burst0_done_clear", int'(done), 0);
    step();

    // half = 0 behaves as half = 1.
    align_tick();
    send(2, 2, 0, 0);
    n = 0;
    do begin step(); n++; end while (ledg[2] != 1'b0 && n < 20);
    chk("half0_toggle", n, 4);
    send(2, 0, 0, 0);

    // Reset in the middle of a burst.
    send(0, 3, 3, 2);
    repeat (5) step();
    key = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("midrst_ledg", int'(ledg), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    step();
    key = 1'b0;
    done_cyc = 0;
    for (int k = 0; k < 10; k++) begin step(); if (done != 0) done_cyc++; end
    chk("midrst_no_done", done_cyc, 0);

    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Time limit so the run always ends.
  initial begin
    #400000;
    errors++;
    $display("FAIL timeout t=%0t reached without completing", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
